// File: rtl/reg_pipeline.sv
// Multi-stage enabled shift register with per-stage valid, occupancy count and taps.
// Latency: DEPTH enabled edges from in_data to out_data; every output is a register or a decode of cnt_q.
// Backpressure: none; a stall (en=0) freezes all state and drops in_*, a full pipeline shifts its oldest entry out.
module reg_pipeline #(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              CW          = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   clr,
    input  logic                   load,
    input  logic [WIDTH-1:0]       load_value,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [DEPTH*WIDTH-1:0] taps,
    output logic [DEPTH-1:0]       tap_valid,
    output logic [CW-1:0]          fill_count,
    output logic                   full,
    output logic                   empty
);

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [CW-1:0]    cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) data_q[k] <= RESET_VALUE;
            valid_q <= '0;
            cnt_q   <= '0;
        end else if (clr) begin
            for (int k = 0; k < DEPTH; k++) data_q[k] <= RESET_VALUE;
            valid_q <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            for (int k = 0; k < DEPTH; k++) data_q[k] <= load_value;
            valid_q <= '1;
            cnt_q   <= CNT_FULL;
        end else if (en) begin
            data_q[0]  <= in_data;
            valid_q[0] <= in_valid;
            for (int k = 1; k < DEPTH; k++) begin
                data_q[k]  <= data_q[k-1];
                valid_q[k] <= valid_q[k-1];
            end
            // Net change is -1, 0 or +1, so the count never leaves 0..DEPTH.
            if (in_valid && !valid_q[DEPTH-1])
                cnt_q <= cnt_q + CW'(1);
            else if (!in_valid && valid_q[DEPTH-1])
                cnt_q <= cnt_q - CW'(1);
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_taps
        assign taps[k*WIDTH +: WIDTH] = data_q[k];
    end

    assign tap_valid  = valid_q;
    assign out_data   = data_q[DEPTH-1];
    assign out_valid  = valid_q[DEPTH-1];
    assign fill_count = cnt_q;
    assign full       = (cnt_q == CNT_FULL);
    assign empty      = (cnt_q == '0);

endmodule

// File: tb/tb_reg_pipeline.sv
// Directed bench for reg_pipeline: an 8x4 instance (reset A5) and a 1x1 instance (reset 1).
module tb_reg_pipeline;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // 8-bit x 4-stage instance
    logic        rst_n, en, clr, load, in_valid;
    logic [7:0]  load_value, in_data, out_data;
    logic        out_valid, full, empty;
    logic [31:0] taps;
    logic [3:0]  tap_valid;
    logic [2:0]  fill_count;

    reg_pipeline #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'hA5)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
        .load_value(load_value), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .taps(taps),
        .tap_valid(tap_valid), .fill_count(fill_count), .full(full), .empty(empty)
    );

    // 1-bit x 1-stage instance
    logic b_rst_n, b_en, b_clr, b_load, b_load_value, b_in_valid, b_in_data;
    logic b_out_valid, b_out_data, b_taps, b_tap_valid, b_fill_count, b_full, b_empty;

    reg_pipeline #(.WIDTH(1), .DEPTH(1), .RESET_VALUE(1'b1)) u_dut_b (
        .clk(clk), .rst_n(b_rst_n), .en(b_en), .clr(b_clr), .load(b_load),
        .load_value(b_load_value), .in_valid(b_in_valid), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_data(b_out_data), .taps(b_taps),
        .tap_valid(b_tap_valid), .fill_count(b_fill_count), .full(b_full), .empty(b_empty)
    );

    logic [7:0] exp_d;
    logic [2:0] exp_f;
    logic       pat [4];

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0; in_valid = 1'b0;
        load_value = 8'h00; in_data = 8'h00;
        b_rst_n = 1'b0; b_en = 1'b0; b_clr = 1'b0; b_load = 1'b0;
        b_load_value = 1'b0; b_in_valid = 1'b0; b_in_data = 1'b0;
        pat[0] = 1'b0; pat[1] = 1'b1; pat[2] = 1'b1; pat[3] = 1'b0;
        step();
        step();
        check("rst_taps",  64'(taps), 64'h0000_0000_A5A5_A5A5);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_fill",  64'(fill_count), 64'd0);
        check("rst_b_out", 64'(b_out_data), 64'd1);
        rst_n = 1'b1;
        b_rst_n = 1'b1;

        // Latency and fill
        en = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            in_data = 8'(i);
            step();
            exp_f = (i >= 4) ? 3'd4 : 3'(i);
            check("fill_cnt", 64'(fill_count), 64'(exp_f));
            check("fill_full", 64'(full), 64'(i >= 4));
            check("fill_ovld", 64'(out_valid), 64'(i >= 4));
            if (i >= 4) check("fill_odat", 64'(out_data), 64'(i - 3));
        end

        // Asynchronous reset in the middle of a cycle
        en = 1'b0;
        #2;
        check("pre_rst_taps", 64'(taps), 64'h0304_0506);
        rst_n = 1'b0;
        #1;
        check("arst_taps",  64'(taps), 64'hA5A5_A5A5);
        check("arst_tvld",  64'(tap_valid), 64'd0);
        check("arst_fill",  64'(fill_count), 64'd0);
        check("arst_empty", 64'(empty), 64'd1);
        check("arst_full",  64'(full), 64'd0);
        check("arst_ovld",  64'(out_valid), 64'd0);
        check("arst_odat",  64'(out_data), 64'hA5);
        rst_n = 1'b1;
        step();

        // Stall with a bubble
        en = 1'b1; in_valid = 1'b1; in_data = 8'h10; step();
        in_valid = 1'b0; in_data = 8'h20; step();
        en = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_taps", 64'(taps), 64'hA5A5_1020);
            check("stall_tvld", 64'(tap_valid), 64'b0010);
            check("stall_fill", 64'(fill_count), 64'd1);
        end
        en = 1'b1; in_valid = 1'b1; in_data = 8'h30; step();
        check("bub_taps", 64'(taps), 64'hA510_2030);
        check("bub_tvld", 64'(tap_valid), 64'b0101);
        check("bub_fill", 64'(fill_count), 64'd2);
        in_valid = 1'b0; in_data = 8'h00;
        step();
        check("drain0_odat", 64'(out_data), 64'h10);
        check("drain0_ovld", 64'(out_valid), 64'd1);
        check("drain0_fill", 64'(fill_count), 64'd2);
        step();
        check("drain1_odat", 64'(out_data), 64'h20);
        check("drain1_ovld", 64'(out_valid), 64'd0);
        check("drain1_fill", 64'(fill_count), 64'd1);
        step();
        check("drain2_odat", 64'(out_data), 64'h30);
        check("drain2_ovld", 64'(out_valid), 64'd1);
        check("drain2_fill", 64'(fill_count), 64'd1);
        step();
        check("drain3_fill",  64'(fill_count), 64'd0);
        check("drain3_empty", 64'(empty), 64'd1);

        // Clear beats load, then load alone
        in_valid = 1'b1; in_data = 8'h11; step();
        in_data = 8'h22; step();
        check("two_fill", 64'(fill_count), 64'd2);
        clr = 1'b1; load = 1'b1; load_value = 8'h3C; in_data = 8'h77; step();
        check("clr_taps",  64'(taps), 64'hA5A5_A5A5);
        check("clr_tvld",  64'(tap_valid), 64'd0);
        check("clr_fill",  64'(fill_count), 64'd0);
        check("clr_empty", 64'(empty), 64'd1);
        clr = 1'b0; step();
        check("load_taps", 64'(taps), 64'h3C3C_3C3C);
        check("load_tvld", 64'(tap_valid), 64'hF);
        check("load_full", 64'(full), 64'd1);
        check("load_fill", 64'(fill_count), 64'd4);
        load = 1'b0;

        // Streaming through a full pipeline
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'h40 + 8'(i);
            step();
            exp_d = (i >= 3) ? 8'h40 + 8'(i - 3) : 8'h3C;
            check("strm_fill", 64'(fill_count), 64'd4);
            check("strm_full", 64'(full), 64'd1);
            check("strm_odat", 64'(out_data), 64'(exp_d));
        end
        in_valid = 1'b0; in_data = 8'h00;
        for (int j = 0; j < 4; j++) begin
            step();
            check("tail_fill", 64'(fill_count), 64'(3 - j));
            check("tail_ovld", 64'(out_valid), 64'(j < 3));
            if (j < 3) check("tail_odat", 64'(out_data), 64'(8'h47 + 8'(j)));
        end
        check("tail_empty", 64'(empty), 64'd1);

        // Single 1-bit stage
        b_en = 1'b1; b_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_in_data = pat[i];
            step();
            check("b_odat", 64'(b_out_data), 64'(pat[i]));
            check("b_full", 64'(b_full), 64'd1);
        end
        b_en = 1'b0; b_in_data = 1'b1; b_in_valid = 1'b0;
        step();
        step();
        check("b_hold_odat", 64'(b_out_data), 64'd0);
        check("b_hold_ovld", 64'(b_out_valid), 64'd1);
        #2;
        b_rst_n = 1'b0;
        #1;
        check("b_arst_odat",  64'(b_out_data), 64'd1);
        check("b_arst_ovld",  64'(b_out_valid), 64'd0);
        check("b_arst_empty", 64'(b_empty), 64'd1);
        b_rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
